// File: rtl/video_meas_pkg.sv
// Shared types and default widths for the video sync monitor.
package video_meas_pkg;
  typedef enum logic [1:0] {IDLE, FIRST, TRACK} state_e;

  localparam int HW_DEF        = 10;
  localparam int VW_DEF        = 10;
  localparam int TIMEOUT_W_DEF = 12;
  localparam int SUM_W         = 16;
endpackage

// File: rtl/sync_pulse_meter.sv
// Edge detector with a saturating period counter and active-width counter.
// Period/width advance on 'step'; the period is latched on the leading edge, the width on the trailing edge.
module sync_pulse_meter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         smp,
  input  logic         act,
  input  logic         step,
  output logic         lead,
  output logic [W-1:0] total_nx,
  output logic [W-1:0] width
);
  localparam logic [W-1:0] MAX = '1;

  logic         prev_q, prev_d;
  logic         trail;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] w_q, w_d;
  logic [W-1:0] tot_q, tot_d;
  logic [W-1:0] wid_q, wid_d;

  // The step coinciding with the leading edge belongs to the new period.
  always_comb begin
    lead   = smp & act & ~prev_q;
    trail  = smp & ~act & prev_q;
    prev_d = smp ? act : prev_q;
    cnt_d  = cnt_q;
    w_d    = w_q;
    tot_d  = tot_q;
    wid_d  = wid_q;
    if (lead) begin
      tot_d = cnt_q;
      cnt_d = W'(step);
      w_d   = W'(step);
    end else if (smp && step) begin
      if (cnt_q != MAX) cnt_d = cnt_q + 1'b1;
      if (act && w_q != MAX) w_d = w_q + 1'b1;
    end
    if (trail) wid_d = w_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      w_q    <= '0;
      tot_q  <= '0;
      wid_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      w_q    <= w_d;
      tot_q  <= tot_d;
      wid_q  <= wid_d;
    end
  end

  assign total_nx = tot_d;
  assign width    = wid_q;
endmodule

// File: rtl/video_sync_monitor.sv
// Samples hsync/vsync/rgb on the pixel strobe, measures line/frame timing,
// sums rgb per frame and reports lock once two frames measure identically.
module video_sync_monitor
  import video_meas_pkg::*;
#(
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   HW        = HW_DEF,
  parameter int   VW        = VW_DEF,
  parameter int   TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [2:0]       rgb,
  output logic [HW-1:0]    h_total,
  output logic [HW-1:0]    h_sync_w,
  output logic [VW-1:0]    v_total,
  output logic [VW-1:0]    v_sync_w,
  output logic [SUM_W-1:0] frame_sum,
  output logic             frame_done,
  output logic             locked
);
  localparam logic [TIMEOUT_W:0] TO_LIM = {1'b0, {TIMEOUT_W{1'b1}}};

  logic             hs_q, hs_d, vs_q, vs_d;
  logic [2:0]       rgb_q, rgb_d;
  logic [SUM_W-1:0] acc_q, acc_d, sum_nx;
  logic [TIMEOUT_W:0] to_q, to_d;
  logic             timeout;
  logic             h_lead, v_lead;
  logic [HW-1:0]    h_tot_nx, h_sw;
  logic [VW-1:0]    v_tot_nx, v_sw;

  state_e           state_q;
  logic [HW-1:0]    h_total_q, h_sync_w_q;
  logic [VW-1:0]    v_total_q, v_sync_w_q;
  logic [SUM_W-1:0] frame_sum_q;
  logic             frame_done_q, locked_q;

  sync_pulse_meter #(.W(HW)) u_hmeter (
    .clk(clk), .reset(reset), .smp(pix_en), .act(hs_q), .step(pix_en),
    .lead(h_lead), .total_nx(h_tot_nx), .width(h_sw)
  );

  sync_pulse_meter #(.W(VW)) u_vmeter (
    .clk(clk), .reset(reset), .smp(pix_en), .act(vs_q), .step(h_lead),
    .lead(v_lead), .total_nx(v_tot_nx), .width(v_sw)
  );

  // The top bit of the timeout counter marks "already fired" so the event is one-shot
  // and a vsync edge arriving after a long gap is not swallowed by a repeating timeout.
  always_comb begin
    hs_d    = pix_en ? (hsync == HSYNC_POL) : hs_q;
    vs_d    = pix_en ? (vsync == VSYNC_POL) : vs_q;
    rgb_d   = pix_en ? rgb : rgb_q;
    sum_nx  = acc_q + SUM_W'(rgb_q);
    acc_d   = acc_q;
    if (v_lead) acc_d = '0;
    else if (pix_en) acc_d = sum_nx;
    to_d    = to_q;
    timeout = 1'b0;
    if (h_lead) to_d = '0;
    else if (pix_en && !to_q[TIMEOUT_W]) begin
      to_d    = to_q + 1'b1;
      timeout = (to_q == TO_LIM);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      rgb_q <= '0;
      acc_q <= '0;
      to_q  <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
      acc_q <= acc_d;
      to_q  <= to_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      h_total_q    <= '0;
      h_sync_w_q   <= '0;
      v_total_q    <= '0;
      v_sync_w_q   <= '0;
      frame_sum_q  <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (timeout) begin
        state_q  <= IDLE;
        locked_q <= 1'b0;
      end else if (v_lead) begin
        case (state_q)
          IDLE: state_q <= FIRST;
          FIRST, TRACK: begin
            state_q      <= TRACK;
            frame_done_q <= 1'b1;
            h_total_q    <= h_tot_nx;
            h_sync_w_q   <= h_sw;
            v_total_q    <= v_tot_nx;
            v_sync_w_q   <= v_sw;
            frame_sum_q  <= sum_nx;
            locked_q     <= (state_q == TRACK) && (h_tot_nx == h_total_q) &&
                            (h_sw == h_sync_w_q) && (v_tot_nx == v_total_q) &&
                            (v_sw == v_sync_w_q);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign h_total    = h_total_q;
  assign h_sync_w   = h_sync_w_q;
  assign v_total    = v_total_q;
  assign v_sync_w   = v_sync_w_q;
  assign frame_sum  = frame_sum_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
endmodule

// File: tb/tb_video_sync_monitor.sv
// Randomized frame generator driving an active-low and an active-high monitor,
// checked against a frame-level timing/checksum model.
module tb_video_sync_monitor;
  localparam int HL  = 40;
  localparam int HSW = 6;
  localparam int VSW = 3;

  typedef struct {
    int ht, hsw, vt, vsw, sum;
    bit lk;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, pix_en, hsync, vsync;
  logic [2:0]  rgb;
  logic [9:0]  h_total, h_sync_w, v_total, v_sync_w;
  logic [9:0]  p_h_total, p_h_sync_w, p_v_total, p_v_sync_w;
  logic [15:0] frame_sum, p_frame_sum;
  logic        frame_done, locked, p_frame_done, p_locked;

  int   n_chk = 0, n_pass = 0, n_done = 0, n_exp = 0;
  exp_t q[$];
  exp_t lat, mon_e;
  int   nlead = 0, acc_m = 0, idx = 0, last_h = 0, gap = 0, pf_vt = 0;
  int   hs0;

  always #5 clk = ~clk;

  video_sync_monitor dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .h_total(h_total), .h_sync_w(h_sync_w), .v_total(v_total), .v_sync_w(v_sync_w),
    .frame_sum(frame_sum), .frame_done(frame_done), .locked(locked)
  );

  video_sync_monitor #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) dut_p (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(~hsync), .vsync(~vsync), .rgb(rgb),
    .h_total(p_h_total), .h_sync_w(p_h_sync_w), .v_total(p_v_total), .v_sync_w(p_v_sync_w),
    .frame_sum(p_frame_sum), .frame_done(p_frame_done), .locked(p_locked)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Every frame_done must match the oldest expected frame record.
  always @(negedge clk) begin
    if (frame_done || p_frame_done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = q.pop_front();
        n_done++;
        chk("done", frame_done, 1);       chk("p_done", p_frame_done, 1);
        chk("h_total", h_total, mon_e.ht);   chk("p_h_total", p_h_total, mon_e.ht);
        chk("h_sync_w", h_sync_w, mon_e.hsw); chk("p_h_sync_w", p_h_sync_w, mon_e.hsw);
        chk("v_total", v_total, mon_e.vt);   chk("p_v_total", p_v_total, mon_e.vt);
        chk("v_sync_w", v_sync_w, mon_e.vsw); chk("p_v_sync_w", p_v_sync_w, mon_e.vsw);
        chk("frame_sum", frame_sum, mon_e.sum); chk("p_frame_sum", p_frame_sum, mon_e.sum);
        chk("locked", locked, mon_e.lk);     chk("p_locked", p_locked, mon_e.lk);
      end
    end
  end

  task automatic check_outs(input string tag);
    chk({tag, "_h_total"}, h_total, lat.ht);    chk({tag, "_h_sync_w"}, h_sync_w, lat.hsw);
    chk({tag, "_v_total"}, v_total, lat.vt);    chk({tag, "_v_sync_w"}, v_sync_w, lat.vsw);
    chk({tag, "_frame_sum"}, frame_sum, lat.sum); chk({tag, "_locked"}, locked, lat.lk);
    chk({tag, "_p_v_total"}, p_v_total, lat.vt); chk({tag, "_p_locked"}, p_locked, lat.lk);
  endtask

  task automatic drive(input bit hv, input bit vv, input bit [2:0] c);
    @(negedge clk);
    hsync = ~hv; vsync = ~vv; rgb = c; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  // A vsync leading edge closes the previous frame: latched line length is the gap between the
  // two most recent hsync leading edges, and the checksum includes the edge sample itself.
  task automatic lead(input int s);
    exp_t e;
    if (nlead >= 1) begin
      e.ht  = (gap > 1023) ? 1023 : gap;
      e.hsw = HSW;
      e.vt  = pf_vt;
      e.vsw = VSW;
      e.sum = s % 65536;
      e.lk  = (nlead >= 2) && e.ht == lat.ht && e.hsw == lat.hsw && e.vt == lat.vt && e.vsw == lat.vsw;
      lat = e;
      q.push_back(e);
      n_exp++;
    end
    nlead++;
  endtask

  task automatic frame(input int vl, input int h0, input int mode);
    bit [2:0] c;
    bit hv, vv;
    for (int y = 0; y < vl; y++)
      for (int x = 0; x < HL; x++) begin
        c  = (mode == 0) ? 3'($urandom) : (mode == 1) ? 3'd1 : 3'd0;
        hv = (x >= h0) && (x < h0 + HSW);
        vv = (y < VSW);
        idx++;
        if (x == h0) begin
          gap    = idx - last_h;
          last_h = idx;
        end
        if (x == 0 && y == 0) begin
          lead(acc_m + c);
          acc_m = 0;
        end else acc_m += c;
        drive(hv, vv, c);
      end
    pf_vt = vl;
  endtask

  task automatic stop_syncs(input int n);
    for (int i = 0; i < n; i++) begin
      idx++;
      drive(1'b0, 1'b0, 3'd0);
    end
    nlead  = 0;
    lat.lk = 1'b0;
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hsync = 1'($urandom); vsync = 1'($urandom); rgb = 3'($urandom); pix_en = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_h_total"}, h_total, 0);  chk({tag, "_h_sync_w"}, h_sync_w, 0);
    chk({tag, "_v_total"}, v_total, 0);  chk({tag, "_v_sync_w"}, v_sync_w, 0);
    chk({tag, "_frame_sum"}, frame_sum, 0); chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_locked"}, locked, 0);    chk({tag, "_p_locked"}, p_locked, 0);
  endtask

  initial begin
    lat = '{default: 0};
    reset = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = 3'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    hs0 = $urandom_range(1, HL - HSW - 1);

    for (int i = 0; i < 4; i++) frame(20, hs0, 0);
    frame(20, hs0, 1);
    frame(20, hs0, 2);
    frame(20, hs0, 0);

    hold_low(300);
    check_outs("pix_low");

    frame(21, hs0, 0);
    frame(21, hs0, 0);
    frame(20, hs0, 0);
    frame(20, hs0, 0);
    for (int i = 0; i < 3; i++) frame($urandom_range(18, 21), hs0, 0);
    frame(20, hs0, 0);
    frame(20, hs0, 0);
    frame(20, hs0, 0);
    chk("locked_before_stop", locked, 1);

    stop_syncs(4200);
    check_outs("timeout");

    for (int i = 0; i < 3; i++) frame(20, hs0, 0);
    for (int i = 0; i < 3; i++) frame(20, 0, 0);

    frame(8, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    nlead = 0;
    lat   = '{default: 0};
    for (int i = 0; i < 3; i++) frame(20, hs0, 0);

    repeat (20) @(negedge clk);
    chk("done_count", n_done, n_exp);
    chk("pending_expected", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
